// File: rtl/vmx_dma_sequencer.sv
// vmx_dma_sequencer: job-level controller for the M_AXI_DMA master.
// Splits a job of cfg_num_beats beats starting at cfg_base_addr into AXI INCR bursts.
// No burst is longer than MAX_BURST beats or crosses a 4 KB page. The DMA master gets
// one burst_init pulse per burst, and the sequencer waits for that burst's burst_done
// before issuing the next one.
//
// Ports:
//   ACLK, ARESET         clock and asynchronous active-high reset
//   cfg_start            one-cycle job start (accepted only when idle)
//   cfg_base_addr        job byte base address (low log2(BYTES) bits ignored)
//   cfg_num_beats        total beats in the job
//   cfg_abort            stop the job at the next burst boundary
//   busy                 job in progress
//   job_done             one-cycle pulse at job end
//   job_error            sticky burst error, cleared on an accepted start
//   job_aborted          sticky abort indication, cleared on an accepted start
//   bursts_done          bursts completed in the current or last job
//   burst_addr/burst_len start address and AXI LEN of the current burst
//   burst_init           one-cycle pulse to the DMA master INIT_AXI_TXN
//   burst_done           TXN_DONE pulse from the DMA master
//   burst_error          DMA master ERROR, sampled with burst_done
module vmx_dma_sequencer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_num_beats,
  input  logic                  cfg_abort,
  output logic                  busy,
  output logic                  job_done,
  output logic                  job_error,
  output logic                  job_aborted,
  output logic [LEN_WIDTH-1:0]  bursts_done,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [7:0]            burst_len,
  output logic                  burst_init,
  input  logic                  burst_done,
  input  logic                  burst_error
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned OFF   = $clog2(BYTES);
  // Wide enough for both the beat count and a full 4 KB page worth of beats.
  localparam int unsigned CW    = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;

  typedef enum logic [2:0] {StIdle, StCalc, StIssue, StWait, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  abort_q, abort_d;
  logic                  busy_q, busy_d;
  logic                  job_done_q, job_done_d;
  logic                  job_error_q, job_error_d;
  logic                  job_aborted_q, job_aborted_d;
  logic [LEN_WIDTH-1:0]  bursts_done_q, bursts_done_d;
  logic [ADDR_WIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [7:0]            burst_len_q, burst_len_d;
  logic                  burst_init_q, burst_init_d;

  logic [12:0]          page_bytes;
  logic [CW-1:0]        page_beats, rem_ext, max_ext, beats_c;
  logic [8:0]           cur_beats;
  logic [LEN_WIDTH-1:0] rem_after;
  logic                 abort_now;

  // Beats left before the next 4 KB page; addr_q is beat-aligned so the shift is exact.
  assign page_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
  assign page_beats = CW'(page_bytes >> OFF);
  assign rem_ext    = CW'(remaining_q);
  assign max_ext    = CW'(MAX_BURST);

  always_comb begin
    beats_c = rem_ext;
    if (max_ext < beats_c)    beats_c = max_ext;
    if (page_beats < beats_c) beats_c = page_beats;
  end

  // The burst in flight is described by burst_len_q, so no separate beat register.
  assign cur_beats = 9'(burst_len_q) + 9'd1;
  assign rem_after = remaining_q - LEN_WIDTH'(cur_beats);
  // An abort arriving together with burst_done still stops the job at that boundary.
  assign abort_now = abort_q | cfg_abort;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    abort_d       = abort_q;
    job_error_d   = job_error_q;
    job_aborted_d = job_aborted_q;
    bursts_done_d = bursts_done_q;
    burst_addr_d  = burst_addr_q;
    burst_len_d   = burst_len_q;

    if (state_q != StIdle && cfg_abort) abort_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          addr_d        = cfg_base_addr & ~ADDR_WIDTH'(BYTES - 1);
          remaining_d   = cfg_num_beats;
          job_error_d   = 1'b0;
          job_aborted_d = 1'b0;
          bursts_done_d = '0;
          abort_d       = 1'b0;
          state_d       = (cfg_num_beats == '0) ? StDone : StCalc;
        end
      end
      StCalc: begin
        burst_len_d  = 8'(beats_c - CW'(1));
        burst_addr_d = addr_q;
        if (abort_now) begin
          job_aborted_d = 1'b1;
          state_d       = StDone;
        end else begin
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (burst_done) begin
          addr_d        = addr_q + (ADDR_WIDTH'(cur_beats) << OFF);
          remaining_d   = rem_after;
          bursts_done_d = bursts_done_q + LEN_WIDTH'(1);
          job_error_d   = job_error_q | burst_error;
          if (abort_now) job_aborted_d = 1'b1;
          if (burst_error || rem_after == '0 || abort_now) state_d = StDone;
          else                                             state_d = StCalc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered off the next state so they line up with the state.
    busy_d       = (state_d != StIdle);
    job_done_d   = (state_d == StDone);
    burst_init_d = (state_d == StIssue);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      remaining_q   <= '0;
      abort_q       <= 1'b0;
      busy_q        <= 1'b0;
      job_done_q    <= 1'b0;
      job_error_q   <= 1'b0;
      job_aborted_q <= 1'b0;
      bursts_done_q <= '0;
      burst_addr_q  <= '0;
      burst_len_q   <= '0;
      burst_init_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      abort_q       <= abort_d;
      busy_q        <= busy_d;
      job_done_q    <= job_done_d;
      job_error_q   <= job_error_d;
      job_aborted_q <= job_aborted_d;
      bursts_done_q <= bursts_done_d;
      burst_addr_q  <= burst_addr_d;
      burst_len_q   <= burst_len_d;
      burst_init_q  <= burst_init_d;
    end
  end

  assign busy        = busy_q;
  assign job_done    = job_done_q;
  assign job_error   = job_error_q;
  assign job_aborted = job_aborted_q;
  assign bursts_done = bursts_done_q;
  assign burst_addr  = burst_addr_q;
  assign burst_len   = burst_len_q;
  assign burst_init  = burst_init_q;

endmodule

// File: tb/tb_vmx_dma_sequencer.sv
// Self-checking bench for vmx_dma_sequencer. The bench contains a directed vector table,
// randomized jobs checked against a burst-splitting reference model, and hand-written
// abort, reset and busy-start sequences.
module tb_vmx_dma_sequencer;
  localparam int MB = 16;
  localparam int BY = 4;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_base_addr = '0;
  logic [15:0] cfg_num_beats = '0;
  logic        cfg_abort = 1'b0;
  logic        busy, job_done, job_error, job_aborted, burst_init;
  logic [15:0] bursts_done;
  logic [31:0] burst_addr;
  logic [7:0]  burst_len;
  logic        burst_done = 1'b0;
  logic        burst_error = 1'b0;

  vmx_dma_sequencer #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(16), .LEN_WIDTH(16)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_num_beats(cfg_num_beats), .cfg_abort(cfg_abort), .busy(busy), .job_done(job_done),
    .job_error(job_error), .job_aborted(job_aborted), .bursts_done(bursts_done),
    .burst_addr(burst_addr), .burst_len(burst_len), .burst_init(burst_init),
    .burst_done(burst_done), .burst_error(burst_error)
  );

  always #5 ACLK = ~ACLK;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference model: the list of bursts a job must produce.
  logic [31:0] m_addr[$];
  logic [7:0]  m_len[$];
  bit          m_err, m_abt;

  task automatic model(input logic [31:0] base, input logic [15:0] beats, input int err_idx,
                       input int abort_idx);
    logic [31:0] a;
    int rem, k;
    a = base & ~32'(BY - 1);
    rem = int'(beats);
    k = 0;
    m_addr.delete();
    m_len.delete();
    m_err = 0;
    m_abt = 0;
    while (rem > 0) begin
      int b, pg;
      pg = (4096 - int'(a % 32'd4096)) / BY;
      b = rem;
      if (b > MB) b = MB;
      if (b > pg) b = pg;
      m_addr.push_back(a);
      m_len.push_back(8'(b - 1));
      a = a + 32'(b * BY);
      rem -= b;
      if (k == err_idx) begin m_err = 1; break; end
      if (k == abort_idx) begin m_abt = 1; break; end
      k++;
    end
  endtask

  logic [31:0] g_addr[$];
  logic [7:0]  g_len[$];

  // Runs one job with a DMA responder. dly<0 picks a random done latency per burst.
  task automatic run_job(input logic [31:0] base, input logic [15:0] beats, input int err_idx,
                         input int abort_idx, input int abort_off, input int dly,
                         input bit spurious);
    int done_at, last_done, n_init, n_jd, jd_cyc, abort_cyc, spur_cyc, cur;
    bit fin;
    done_at = -1; last_done = -1; n_init = 0; n_jd = 0; jd_cyc = -1;
    abort_cyc = -1; spur_cyc = -1; cur = -1; fin = 0;
    g_addr.delete();
    g_len.delete();
    cfg_base_addr = base;
    cfg_num_beats = beats;
    cfg_start = 1;
    tick();
    cfg_start = 0;
    chk("busy_cycle1", longint'(busy), 1);
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      burst_done = 0; burst_error = 0; cfg_abort = 0; cfg_start = 0;
      if (burst_init) begin
        chk("init_time", cyc, (n_init == 0) ? 2 : last_done + 2);
        cur = n_init;
        n_init++;
        g_addr.push_back(burst_addr);
        g_len.push_back(burst_len);
        done_at = cyc + 1 + ((dly >= 0) ? dly : int'($urandom_range(0, 6)));
        if (cur == abort_idx) abort_cyc = cyc + 1 + abort_off;
        if (spurious && cur == 0) spur_cyc = cyc + 1;
      end
      if (job_done) begin
        n_jd++;
        if (jd_cyc < 0) begin
          chk("job_done_time", cyc, (beats == 0) ? 1 : last_done + 1);
          jd_cyc = cyc;
        end
      end
      if (jd_cyc >= 0 && cyc == jd_cyc + 1) begin
        chk("busy_after_done", longint'(busy), 0);
        fin = 1;
      end
      if (cyc == done_at) begin
        burst_done = 1;
        burst_error = (cur == err_idx);
        chk("addr_hold", longint'(burst_addr), longint'(g_addr[cur]));
        last_done = cyc;
      end
      if (cyc == abort_cyc) cfg_abort = 1;
      if (cyc == spur_cyc) begin
        cfg_start = 1; cfg_base_addr = 32'h9000; cfg_num_beats = 16'd4;
      end
      if (!fin) tick();
    end
    burst_done = 0; burst_error = 0; cfg_abort = 0; cfg_start = 0;
    if (!fin) chk("job_timeout", 0, 1);
    chk("job_done_count", n_jd, 1);
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_nbursts"}, g_addr.size(), m_addr.size());
    for (int i = 0; i < m_addr.size() && i < g_addr.size(); i++) begin
      chk({tag, "_addr"}, longint'(g_addr[i]), longint'(m_addr[i]));
      chk({tag, "_len"}, longint'(g_len[i]), longint'(m_len[i]));
    end
    chk({tag, "_bursts_done"}, longint'(bursts_done), m_addr.size());
    chk({tag, "_job_error"}, longint'(job_error), longint'(m_err));
    chk({tag, "_job_aborted"}, longint'(job_aborted), longint'(m_abt));
  endtask

  typedef struct {
    logic [31:0]      base;
    logic [15:0]      beats;
    int               err_idx;
    int               exp_n;
    logic [2:0][31:0] ea;
    logic [2:0][7:0]  el;
    bit               exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h1000, 16'd40, -1, 3, {32'h1080, 32'h1040, 32'h1000}, {8'd7, 8'd15, 8'd15}, 1'b0};
    vecs[1] = '{32'h0FF8, 16'd8, -1, 2, {32'h0, 32'h1000, 32'h0FF8}, {8'd0, 8'd5, 8'd1}, 1'b0};
    vecs[2] = '{32'h0, 16'd0, -1, 0, {32'h0, 32'h0, 32'h0}, {8'd0, 8'd0, 8'd0}, 1'b0};
    vecs[3] = '{32'h2000, 16'd40, 1, 2, {32'h0, 32'h2040, 32'h2000}, {8'd0, 8'd15, 8'd15}, 1'b1};
    vecs[4] = '{32'h3000, 16'd16, -1, 1, {32'h0, 32'h0, 32'h3000}, {8'd0, 8'd0, 8'd15}, 1'b0};
    vecs[5] = '{32'h0FF3, 16'd5, -1, 2, {32'h0, 32'h1000, 32'h0FF0}, {8'd0, 8'd0, 8'd3}, 1'b0};
    vecs[6] = '{32'hFFFF_FFF8, 16'd4, -1, 2, {32'h0, 32'h0, 32'hFFFF_FFF8}, {8'd0, 8'd1, 8'd1}, 1'b0};

    ARESET = 1;
    tick();
    tick();
    chk("reset_busy", longint'(busy), 0);
    chk("reset_job_done", longint'(job_done), 0);
    chk("reset_burst_init", longint'(burst_init), 0);
    chk("reset_bursts_done", longint'(bursts_done), 0);
    chk("reset_burst_addr", longint'(burst_addr), 0);
    chk("reset_burst_len", longint'(burst_len), 0);
    chk("reset_flags", longint'({job_error, job_aborted}), 0);
    ARESET = 0;
    tick();

    for (int v = 0; v < 7; v++) begin
      run_job(vecs[v].base, vecs[v].beats, vecs[v].err_idx, -1, 0, 5, 0);
      chk("vec_nbursts", g_addr.size(), vecs[v].exp_n);
      for (int i = 0; i < vecs[v].exp_n && i < g_addr.size(); i++) begin
        chk("vec_addr", longint'(g_addr[i]), longint'(vecs[v].ea[i]));
        chk("vec_len", longint'(g_len[i]), longint'(vecs[v].el[i]));
      end
      chk("vec_bursts_done", longint'(bursts_done), vecs[v].exp_n);
      chk("vec_job_error", longint'(job_error), longint'(vecs[v].exp_err));
      chk("vec_job_aborted", longint'(job_aborted), 0);
      model(vecs[v].base, vecs[v].beats, vecs[v].err_idx, -1);
      cmp_model("vec_model");
    end

    // Abort in the middle of the first burst's wait.
    run_job(32'h4000, 16'd40, -1, 0, 1, 5, 0);
    model(32'h4000, 16'd40, -1, 0);
    cmp_model("abort_mid");
    // Abort in the same cycle as burst_done.
    run_job(32'h4000, 16'd40, -1, 0, 4, 4, 0);
    model(32'h4000, 16'd40, -1, 0);
    cmp_model("abort_same");
    // cfg_start while busy must be ignored; the new job also clears job_aborted.
    run_job(32'h5000, 16'd40, -1, -1, 0, 3, 1);
    model(32'h5000, 16'd40, -1, -1);
    cmp_model("start_busy");

    // Reset in the middle of a wait: outputs drop immediately and no job_done follows.
    begin
      bit seen;
      seen = 0;
      cfg_base_addr = 32'h1000; cfg_num_beats = 16'd40; cfg_start = 1;
      tick();
      cfg_start = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (burst_init) seen = 1;
        else tick();
      end
      chk("rst_mid_init_seen", longint'(seen), 1);
      tick();
      tick();
      ARESET = 1;
      #1;
      chk("rst_mid_busy", longint'(busy), 0);
      chk("rst_mid_addr", longint'(burst_addr), 0);
      chk("rst_mid_len", longint'(burst_len), 0);
      chk("rst_mid_bursts_done", longint'(bursts_done), 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("rst_mid_no_done", longint'({job_done, burst_init}), 0);
      end
      ARESET = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("rst_mid_idle", longint'({busy, job_done, burst_init}), 0);
      end
    end

    for (int r = 0; r < 25; r++) begin
      logic [31:0] base;
      logic [15:0] beats;
      int err;
      base = $urandom;
      if ($urandom_range(0, 1) == 1) base[11:0] = 12'(4096 - 4 * int'($urandom_range(1, 20)));
      beats = 16'($urandom_range(0, 70));
      err = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_job(base, beats, err, -1, 0, -1, 0);
      model(base, beats, err, -1);
      cmp_model("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
